alu: RTL and testbench

- 8-bit registered ALU for the CPU datapath, with a Game Boy style operation set: ADD, ADC, SUB, SBC, AND, XOR, OR, CP.
- Combinationally computes a result and a 4-bit flag nibble (Z, N, H, C) from A, B, flags_in and operation.
- Captures the result and flags in output registers on the rising clock edge.
- Bench-side signals are bundled in interface alu_iface: clock input plus A, B, flags_in, operation, Z, flags_out.

---
 rtl/alu_if.sv | 11 +
 rtl/alu.sv | 88 ++++++++
 tb/tb_alu.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// Bench-side bundle for the registered ALU: clock plus operand, opcode and result signals.
interface alu_iface (
    input logic clock
);
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] flags_in;
    logic [2:0] operation;
    logic [7:0] Z;
    logic [3:0] flags_out;
endinterface

// File: rtl/alu.sv
// 8-bit registered ALU with a Game Boy style operation set and {Z,N,H,C} flags.
// One combinational compute stage feeds the result and flag registers (1-cycle latency).
module alu (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [3:0] flags_in,
    input  logic [2:0] operation,
    output logic [7:0] Z,
    output logic [3:0] flags_out
);

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_ADC = 3'd1,
        OP_SUB = 3'd2,
        OP_SBC = 3'd3,
        OP_AND = 3'd4,
        OP_XOR = 3'd5,
        OP_OR  = 3'd6,
        OP_CP  = 3'd7
    } op_t;

    op_t        op;
    logic       cin;
    logic [8:0] wide;
    logic [4:0] nib;
    logic [7:0] result;
    logic [7:0] z_next;
    logic       flag_n;
    logic       flag_h;
    logic       flag_c;
    logic       unused_flags;

    assign op           = op_t'(operation);
    // Only the carry bit of the incoming flags participates.
    assign unused_flags = ^flags_in[3:1];

    always_comb begin
        cin    = 1'b0;
        wide   = 9'h000;
        nib    = 5'h00;
        result = 8'h00;
        flag_n = 1'b0;
        flag_h = 1'b0;
        flag_c = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                cin    = (op == OP_ADC) ? flags_in[0] : 1'b0;
                wide   = {1'b0, A} + {1'b0, B} + {8'h00, cin};
                nib    = {1'b0, A[3:0]} + {1'b0, B[3:0]} + {4'h0, cin};
                result = wide[7:0];
                flag_h = nib[4];
                flag_c = wide[8];
            end
            OP_SUB, OP_SBC, OP_CP: begin
                // Bit 8 / bit 4 of the extended difference is the borrow out.
                cin    = (op == OP_SBC) ? flags_in[0] : 1'b0;
                wide   = {1'b0, A} - {1'b0, B} - {8'h00, cin};
                nib    = {1'b0, A[3:0]} - {1'b0, B[3:0]} - {4'h0, cin};
                result = wide[7:0];
                flag_n = 1'b1;
                flag_h = nib[4];
                flag_c = wide[8];
            end
            OP_AND: begin
                result = A & B;
                flag_h = 1'b1;
            end
            OP_XOR: result = A ^ B;
            OP_OR:  result = A | B;
            default: result = 8'h00;
        endcase
        z_next = (op == OP_CP) ? A : result;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Z         <= 8'h00;
            flags_out <= 4'h0;
        end else begin
            Z         <= z_next;
            flags_out <= {(result == 8'h00), flag_n, flag_h, flag_c};
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed, table-driven self-checking bench for the registered ALU.
module tb_alu;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    alu_iface bus (.clock(clock));

    alu dut (
        .clock    (clock),
        .reset    (reset),
        .A        (bus.A),
        .B        (bus.B),
        .flags_in (bus.flags_in),
        .operation(bus.operation),
        .Z        (bus.Z),
        .flags_out(bus.flags_out)
    );

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] fin;
        logic [7:0] exp_z;
        logic [3:0] exp_f;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] exp_z, input logic [3:0] exp_f);
        checks++;
        if (bus.Z !== exp_z || bus.flags_out !== exp_f) begin
            errors++;
            $display("FAIL %s: got Z=%02h flags=%04b, expected Z=%02h flags=%04b",
                     name, bus.Z, bus.flags_out, exp_z, exp_f);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] fin);
        @(negedge clock);
        bus.operation = op;
        bus.A         = a;
        bus.B         = b;
        bus.flags_in  = fin;
    endtask

    initial begin
        logic [7:0] sum;
        logic [7:0] prev_z;
        logic [3:0] prev_f;
        logic [7:0] seq_z[4];
        logic [3:0] seq_f[4];
        logic [2:0] seq_op[4];

        vecs.push_back('{"adc_cin",      3'd1, 8'h0F, 8'h00, 4'b0001, 8'h10, 4'b0010});
        vecs.push_back('{"sbc_cin",      3'd3, 8'h10, 8'h0F, 4'b0001, 8'h00, 4'b1110});
        vecs.push_back('{"sbc_hi_flags", 3'd3, 8'h10, 8'h0F, 4'b1110, 8'h01, 4'b0110});
        vecs.push_back('{"sub_wrap",     3'd2, 8'h01, 8'h02, 4'b0000, 8'hFF, 4'b0111});
        vecs.push_back('{"cp_equal",     3'd7, 8'h01, 8'h01, 4'b0000, 8'h01, 4'b1100});
        vecs.push_back('{"cp_less",      3'd7, 8'h05, 8'h10, 4'b0000, 8'h05, 4'b0101});
        vecs.push_back('{"and_zero",     3'd4, 8'h0F, 8'hF0, 4'b0000, 8'h00, 4'b1010});
        vecs.push_back('{"xor_ff",       3'd5, 8'hAA, 8'h55, 4'b0000, 8'hFF, 4'b0000});
        vecs.push_back('{"or_zero",      3'd6, 8'h00, 8'h00, 4'b0000, 8'h00, 4'b1000});
        vecs.push_back('{"add_wrap",     3'd0, 8'hFF, 8'h01, 4'b0000, 8'h00, 4'b1011});
        vecs.push_back('{"sub_00_01",    3'd2, 8'h00, 8'h01, 4'b0000, 8'hFF, 4'b0111});
        vecs.push_back('{"adc_wrap",     3'd1, 8'hFF, 8'h00, 4'b0001, 8'h00, 4'b1011});
        vecs.push_back('{"add_no_cin",   3'd0, 8'h0F, 8'h00, 4'b0001, 8'h0F, 4'b0000});

        bus.A = 8'h00; bus.B = 8'h00; bus.flags_in = 4'h0; bus.operation = 3'd0;
        reset = 1'b1;
        #2;
        check("reset_initial", 8'h00, 4'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Reset mid-stream with nonzero outputs, cleared without a clock edge
        drive(3'd5, 8'hAA, 8'h55, 4'h0);
        @(posedge clock); #1;
        check("pre_reset_xor", 8'hFF, 4'b0000);
        #2;
        reset = 1'b1;
        #1;
        check("reset_async", 8'h00, 4'h0);
        @(negedge clock);
        reset = 1'b0;
        drive(3'd0, 8'h01, 8'h01, 4'h0);
        @(posedge clock); #1;
        check("post_reset_add", 8'h02, 4'b0000);

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].fin);
            @(posedge clock); #1;
            check(vecs[i].name, vecs[i].exp_z, vecs[i].exp_f);
        end

        // ADD sweep: A=01, B=00..FF, one value per cycle
        for (int b = 0; b < 256; b++) begin
            drive(3'd0, 8'h01, 8'(b), 4'h0);
            @(posedge clock); #1;
            sum = 8'(b + 1);
            if (b == 8'h0F)
                check("sweep_b0f", 8'h10, 4'b0010);
            else if (b == 8'hFF)
                check("sweep_bff", 8'h00, 4'b1011);
            else
                check("sweep_add", sum, {1'b0, 1'b0, (b[3:0] == 4'hF), 1'b0});
        end

        // Back-to-back ops with fixed operands; output must not change before the edge
        seq_op[0] = 3'd0; seq_z[0] = 8'h00; seq_f[0] = 4'b1011;
        seq_op[1] = 3'd2; seq_z[1] = 8'h78; seq_f[1] = 4'b0101;
        seq_op[2] = 3'd4; seq_z[2] = 8'h04; seq_f[2] = 4'b0010;
        seq_op[3] = 3'd7; seq_z[3] = 8'h3C; seq_f[3] = 4'b0101;
        prev_z = 8'h00;
        prev_f = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            drive(seq_op[i], 8'h3C, 8'hC4, 4'h0);
            #1;
            if (i > 0) check("b2b_hold", prev_z, prev_f);
            @(posedge clock); #1;
            check("b2b_result", seq_z[i], seq_f[i]);
            prev_z = seq_z[i];
            prev_f = seq_f[i];
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
